// File: rtl/inst_mem_resp.sv
// inst_mem_resp: instruction-memory responder with wait states, write-first load port and flush.
// Define INST_MEM_ERR_EN to flag misaligned or out-of-range fetches through resp_err.
module inst_mem_resp #(
   parameter int DEPTH_WORDS = 1024,
   parameter int WAIT_CYCLES = 1
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           req_valid,
   output logic                           req_ready,
   input  logic [31:0]                    req_addr,
   output logic                           resp_valid,
   input  logic                           resp_ready,
   output logic [31:0]                    resp_inst,
   output logic                           resp_err,
   input  logic                           flush,
   input  logic                           ld_en,
   input  logic [$clog2(DEPTH_WORDS)-1:0] ld_addr,
   input  logic [31:0]                    ld_data
);
   localparam int AW = $clog2(DEPTH_WORDS);
   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
   state_t      state, state_nxt;
   logic [3:0]  cnt, cnt_nxt;
   logic [31:0] addr_q, rd_addr, rd_word;
   logic [31:0] mem [DEPTH_WORDS];
   logic [AW-1:0] rd_idx;
   logic        accept, enter_resp, rd_err;

   assign req_ready  = !rst && !flush && (state == IDLE || (state == RESP && resp_ready));
   assign accept     = req_valid && req_ready;
   assign resp_valid = state == RESP;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      if (flush) begin
         state_nxt = IDLE;
         cnt_nxt   = '0;
      end else if (accept) begin
         state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
         cnt_nxt   = 4'(WAIT_CYCLES);
      end else if (state == WAIT) begin
         if (cnt == 4'd0) state_nxt = RESP;
         else cnt_nxt = cnt - 4'd1;
      end else if (state == RESP && resp_ready) begin
         state_nxt = IDLE;
      end
   end

   // With zero wait states the read happens on the accept edge, so use the live address
   assign enter_resp = state_nxt == RESP && (state != RESP || accept);
   assign rd_addr    = accept ? req_addr : addr_q;
   assign rd_idx     = rd_addr[AW+1:2];
   assign rd_word    = (ld_en && ld_addr == rd_idx) ? ld_data : mem[rd_idx];

`ifdef INST_MEM_ERR_EN
   assign rd_err = |rd_addr[1:0] || |rd_addr[31:AW+2];
`else
   logic unused_addr;
   assign unused_addr = ^{rd_addr[1:0], rd_addr[31:AW+2]};
   assign rd_err      = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (ld_en) mem[ld_addr] <= ld_data;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         addr_q    <= '0;
         resp_inst <= '0;
         resp_err  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         if (accept) addr_q <= req_addr;
         if (enter_resp) begin
            resp_err  <= rd_err;
            resp_inst <= rd_err ? 32'h0 : rd_word;
         end
      end
   end
endmodule
